// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus a small memory-mapped IO page (UART TX/RX FIFOs, cycle counter, stop flag).
// One CPU access per rdy_in cycle; read data is registered onto mem_din.
module mem_io_responder #(
    parameter int RAM_AW  = 17,
    parameter int FIFO_AW = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_stop
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] CNT_NEAR = CNT_FULL - (FIFO_AW + 1)'(2);

    localparam logic [31:0] ADDR_UART  = 32'h0003_0000;
    localparam logic [31:0] ADDR_CNT0  = 32'h0003_0004;
    localparam logic [31:0] ADDR_CNT1  = 32'h0003_0005;
    localparam logic [31:0] ADDR_CNT2  = 32'h0003_0006;
    localparam logic [31:0] ADDR_CNT3  = 32'h0003_0007;

    logic [7:0] ram [0:(1 << RAM_AW) - 1];
    logic [7:0] tx_mem [0:DEPTH-1];
    logic [7:0] rx_mem [0:DEPTH-1];

    logic               is_io;
    logic               wr_acc;
    logic               rd_acc;
    logic [FIFO_AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [FIFO_AW:0]   tx_count, rx_count;
    logic               tx_full, tx_empty, rx_full, rx_empty;
    logic               tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0]        cycle_cnt;
    logic [31:0]        snapshot;
    logic [7:0]         io_rdata;

    assign is_io  = (mem_a[17:16] == 2'b11);
    assign wr_acc = rdy_in & mem_wr;
    assign rd_acc = rdy_in & ~mem_wr;

    assign tx_full  = (tx_count == CNT_FULL);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);
    assign rx_empty = (rx_count == '0);

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign tx_pop  = ~tx_empty & tx_ready;
    assign tx_push = wr_acc & (mem_a == ADDR_UART) & (mem_dout != 8'h00) & (~tx_full | tx_pop);
    assign rx_pop  = rd_acc & (mem_a == ADDR_UART) & ~rx_empty;
    assign rx_push = rx_valid & (~rx_full | rx_pop);

    assign tx_valid       = ~tx_empty;
    assign tx_data        = tx_mem[tx_rptr];
    // Registered count only; the two-entry margin covers writes already in flight.
    assign io_buffer_full = (tx_count >= CNT_NEAR);

    always_comb begin
        io_rdata = 8'h00;
        case (mem_a)
            ADDR_UART: io_rdata = rx_empty ? 8'h00 : rx_mem[rx_rptr];
            ADDR_CNT0: io_rdata = cycle_cnt[7:0];
            ADDR_CNT1: io_rdata = snapshot[15:8];
            ADDR_CNT2: io_rdata = snapshot[23:16];
            ADDR_CNT3: io_rdata = snapshot[31:24];
            default:   io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (wr_acc && !is_io) begin
            ram[mem_a[RAM_AW-1:0]] <= mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= mem_dout;
        end
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din <= 8'h00;
        end else if (rd_acc) begin
            mem_din <= is_io ? io_rdata : ram[mem_a[RAM_AW-1:0]];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cycle_cnt    <= 32'd0;
            snapshot     <= 32'd0;
            program_stop <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rd_acc && mem_a == ADDR_CNT0) begin
                snapshot <= cycle_cnt;
            end
            if (wr_acc && mem_a == ADDR_CNT0) begin
                program_stop <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 The module SHALL have parameter RAM_AW, default 17, meaning RAM byte-address width (2^RAM_AW bytes).
REQ-002 The module SHALL have parameter FIFO_AW, default 3, meaning log2 depth of each of the TX and RX FIFOs (depth D = 2^FIFO_AW).
REQ-003 The module SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The module SHALL have port clk_in, input, width 1: system clock.
REQ-005 The module SHALL have port rst_in, input, width 1: asynchronous active-high reset.
REQ-006 The module SHALL have port rdy_in, input, width 1: bus accesses are ignored when low.
REQ-007 The module SHALL have port mem_a, input, width 32: CPU byte address.
REQ-008 The module SHALL have port mem_wr, input, width 1: 1 = write, 0 = read.
REQ-009 The module SHALL have port mem_dout, input, width 8: CPU write data.
REQ-010 The module SHALL have port mem_din, output, width 8: read data returned to the CPU.
REQ-011 The module SHALL have port io_buffer_full, output, width 1: TX FIFO near-full.
REQ-012 The module SHALL have port tx_data, output, width 8: UART TX byte.
REQ-013 The module SHALL have port tx_valid, output, width 1: tx_data is valid.
REQ-014 The module SHALL have port tx_ready, input, width 1: UART accepts tx_data.
REQ-015 The module SHALL have port rx_data, input, width 8: UART RX byte.
REQ-016 The module SHALL have port rx_valid, input, width 1: rx_data is valid this cycle (single-cycle pulse per byte).
REQ-017 The module SHALL have port program_stop, output, width 1: sticky program-end flag.

Function
REQ-018 The module SHALL decode an access as IO when mem_a[17:16]==2'b11 and as RAM otherwise, with the RAM index = mem_a[RAM_AW-1:0].
REQ-019 An access SHALL take effect only on a rising clk_in edge with rdy_in=1; with rdy_in=0 there SHALL be no RAM write, no FIFO push/pop, no snapshot, and mem_din SHALL hold its value.
REQ-020 A RAM write SHALL store mem_dout at the indexed byte at that edge.
REQ-021 A RAM read SHALL register the byte into mem_din at that edge, making it visible in the following cycle (1-cycle latency).
REQ-022 A read issued the cycle after a write to the same address SHALL return the new byte.
REQ-023 A write to 0x30000 with mem_dout!=0 and the TX FIFO not full SHALL push mem_dout.
REQ-024 A write to 0x30000 with mem_dout==0 SHALL be ignored; when the TX FIFO is full the byte SHALL be dropped.
REQ-025 A write to 0x30004 SHALL set program_stop=1, which remains set until reset.
REQ-026 A read of 0x30000 SHALL return the RX FIFO head and pop it; when the RX FIFO is empty it SHALL return 0x00 with no pop.
REQ-027 Cycle counter: 32-bit, +1 every clk_in edge regardless of rdy_in, wraps 0xFFFFFFFF->0.
REQ-028 A read of 0x30004 SHALL return counter[7:0] and latch the full counter into a snapshot register.
REQ-029 Reads of 0x30005/0x30006/0x30007 SHALL return snapshot bytes [15:8]/[23:16]/[31:24] (little-endian, coherent).
REQ-030 Reads of any other IO address SHALL return 0x00; writes to any other IO address SHALL be ignored.
REQ-031 TX FIFO output: tx_valid = !empty; tx_data = head; pop on tx_valid && tx_ready.
REQ-032 The TX FIFO SHALL allow simultaneous push and pop with the count unchanged; a push into a full FIFO with a same-cycle pop SHALL be accepted.
REQ-033 io_buffer_full SHALL equal (TX count >= D-2), derived from registered count only (margin for CPU write latency).
REQ-034 RX FIFO: push rx_data on rx_valid when not full (dropped when full, unless a pop occurs the same cycle); pop per REQ-026.
REQ-035 FIFO pointers SHALL be FIFO_AW bits, wrap modulo D, with a separate FIFO_AW+1-bit count for full/empty.

Reset
REQ-036 On rst_in=1 (asynchronous), the following SHALL be cleared: mem_din=0, program_stop=0, counter=0, snapshot=0, and both FIFO pointers and counts = 0 (tx_valid=0, io_buffer_full=0).
REQ-037 RAM contents SHALL NOT be cleared by reset.
REQ-038 Reset asserted mid-operation SHALL discard in-flight FIFO contents, and the read data of the access pending at reset assertion SHALL be lost (mem_din=0).
REQ-039 After deassertion the counter SHALL read 0 at the first edge and count from there.

Verification
REQ-040 Write 0xA5 to 0x00010, then read 0x00010 the next cycle -> mem_din=0xA5 one cycle after the read; with rdy_in=0 during the read cycle, mem_din SHALL be unchanged.
REQ-041 Write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=0 -> count=2; raise tx_ready -> tx_data 0x41 then 0x42, then tx_valid=0.
REQ-042 D=8, tx_ready=0, 7 nonzero writes -> io_buffer_full=1 from count 6; 8th and 9th writes -> 9th dropped (count=8).
REQ-043 Pulse rx_valid with 0x33 then 0x44; read 0x30000 three times -> 0x33, 0x44, 0x00.
REQ-044 Read 0x30004 at counter 0x000001FF, then read 0x30005 later -> 0xFF, then 0x01 (snapshot, not live); write 0x30004 -> program_stop=1 until rst_in.
REQ-045 Assert rst_in asynchronously mid-TX-drain -> tx_valid=0, mem_din=0 immediately; previously written RAM bytes SHALL be retained.
